// File: rtl/vproc_pkg.sv
// Shared types and helpers for the vector processor hazard logic.
// Slot ids and hazard masks used by the issue tracker.
package vproc_pkg;

  localparam int unsigned VREG_CNT_DEF = 32;

  typedef logic [VREG_CNT_DEF-1:0] hazard_mask_t;

  function automatic int unsigned id_width(input int unsigned op_cnt);
    return (op_cnt > 1) ? $clog2(op_cnt) : 1;
  endfunction

endpackage

// File: rtl/vproc_hazard_slot.sv
// One in-flight operation slot: busy flag plus pending read/write masks.
// Clears are matched against this slot's id on every completion port.
module vproc_hazard_slot
  import vproc_pkg::*;
#(
  parameter int unsigned VREG_CNT = 32,
  parameter int unsigned PIPE_CNT = 2,
  parameter int unsigned IDW      = 3,
  parameter int unsigned SLOT_ID  = 0
) (
  input  logic                          clk_i,
  input  logic                          async_rst_ni,
  input  logic                          alloc_i,
  input  logic [VREG_CNT-1:0]           rd_mask_i,
  input  logic [VREG_CNT-1:0]           wr_mask_i,
  input  logic [PIPE_CNT-1:0]           rd_clear_valid_i,
  input  logic [PIPE_CNT-1:0][IDW-1:0]  rd_clear_id_i,
  input  logic [PIPE_CNT-1:0]           wr_clear_valid_i,
  input  logic [PIPE_CNT-1:0][IDW-1:0]  wr_clear_id_i,
  output logic                          busy_o,
  output logic [VREG_CNT-1:0]           rd_mask_o,
  output logic [VREG_CNT-1:0]           wr_mask_o
);

  localparam logic [IDW-1:0] MY_ID = IDW'(SLOT_ID);

  logic                busy_q, busy_d;
  logic [VREG_CNT-1:0] rd_q, rd_d;
  logic [VREG_CNT-1:0] wr_q, wr_d;
  logic                rd_hit, wr_hit;

  always_comb begin
    rd_hit = 1'b0;
    wr_hit = 1'b0;
    for (int p = 0; p < int'(PIPE_CNT); p++) begin
      if (rd_clear_valid_i[p] && rd_clear_id_i[p] == MY_ID) rd_hit = 1'b1;
      if (wr_clear_valid_i[p] && wr_clear_id_i[p] == MY_ID) wr_hit = 1'b1;
    end
  end

  // A busy slot lives only while some mask is still pending.
  always_comb begin
    busy_d = busy_q;
    rd_d   = rd_q;
    wr_d   = wr_q;
    unique case (1'b1)
      alloc_i: begin
        busy_d = 1'b1;
        rd_d   = rd_mask_i;
        wr_d   = wr_mask_i;
      end
      busy_q: begin
        if (rd_hit) rd_d = '0;
        if (wr_hit) wr_d = '0;
        busy_d = (rd_d != '0) || (wr_d != '0);
      end
      default: begin
        busy_d = 1'b0;
        rd_d   = '0;
        wr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge async_rst_ni) begin
    if (!async_rst_ni) begin
      busy_q <= 1'b0;
      rd_q   <= '0;
      wr_q   <= '0;
    end else begin
      busy_q <= busy_d;
      rd_q   <= rd_d;
      wr_q   <= wr_d;
    end
  end

  assign busy_o    = busy_q;
  assign rd_mask_o = rd_q;
  assign wr_mask_o = wr_q;

endmodule

// File: rtl/vproc_hazard_tracker.sv
// Tracks vector register read/write hazards of in-flight operations.
// Issue is gated on registered state only; clears take effect next cycle.
module vproc_hazard_tracker
  import vproc_pkg::*;
#(
  parameter int unsigned VREG_CNT = 32,
  parameter int unsigned OP_CNT   = 8,
  parameter int unsigned PIPE_CNT = 2
) (
  input  logic                                       clk_i,
  input  logic                                       async_rst_ni,
  input  logic                                       issue_valid_i,
  output logic                                       issue_ready_o,
  input  logic [VREG_CNT-1:0]                        issue_rd_hazards_i,
  input  logic [VREG_CNT-1:0]                        issue_wr_hazards_i,
  output logic [$clog2(OP_CNT)-1:0]                  issue_id_o,
  input  logic [PIPE_CNT-1:0]                        rd_clear_valid_i,
  input  logic [PIPE_CNT-1:0][$clog2(OP_CNT)-1:0]    rd_clear_id_i,
  input  logic [PIPE_CNT-1:0]                        wr_clear_valid_i,
  input  logic [PIPE_CNT-1:0][$clog2(OP_CNT)-1:0]    wr_clear_id_i,
  output logic [VREG_CNT-1:0]                        pend_reads_o,
  output logic [VREG_CNT-1:0]                        pend_writes_o,
  output logic [$clog2(OP_CNT):0]                    inflight_o
);

  localparam int unsigned IDW = id_width(OP_CNT);

  logic [OP_CNT-1:0]               busy;
  logic [OP_CNT-1:0]               alloc;
  logic [OP_CNT-1:0][VREG_CNT-1:0] rd_mask;
  logic [OP_CNT-1:0][VREG_CNT-1:0] wr_mask;
  logic [IDW-1:0]                  free_id;
  logic                            any_free;
  logic                            conflict;
  logic                            accept;

  for (genvar i = 0; i < int'(OP_CNT); i++) begin : g_slot
    assign alloc[i] = accept && (free_id == IDW'(i));

    vproc_hazard_slot #(
      .VREG_CNT (VREG_CNT),
      .PIPE_CNT (PIPE_CNT),
      .IDW      (IDW),
      .SLOT_ID  (i)
    ) u_slot (
      .clk_i            (clk_i),
      .async_rst_ni     (async_rst_ni),
      .alloc_i          (alloc[i]),
      .rd_mask_i        (issue_rd_hazards_i),
      .wr_mask_i        (issue_wr_hazards_i),
      .rd_clear_valid_i (rd_clear_valid_i),
      .rd_clear_id_i    (rd_clear_id_i),
      .wr_clear_valid_i (wr_clear_valid_i),
      .wr_clear_id_i    (wr_clear_id_i),
      .busy_o           (busy[i]),
      .rd_mask_o        (rd_mask[i]),
      .wr_mask_o        (wr_mask[i])
    );
  end

  // Lowest-index free slot wins; scan high to low so the last hit sticks.
  always_comb begin
    free_id = '0;
    for (int i = int'(OP_CNT) - 1; i >= 0; i--) begin
      if (!busy[i]) free_id = IDW'(i);
    end
  end

  always_comb begin
    pend_reads_o  = '0;
    pend_writes_o = '0;
    inflight_o    = '0;
    for (int i = 0; i < int'(OP_CNT); i++) begin
      pend_reads_o  = pend_reads_o  | (rd_mask[i] & {VREG_CNT{busy[i]}});
      pend_writes_o = pend_writes_o | (wr_mask[i] & {VREG_CNT{busy[i]}});
      inflight_o    = inflight_o + ($clog2(OP_CNT)+1)'(busy[i]);
    end
  end

  assign any_free = ~&busy;
  assign conflict = ((issue_rd_hazards_i & pend_writes_o) != '0) ||
                    ((issue_wr_hazards_i & pend_reads_o)  != '0) ||
                    ((issue_wr_hazards_i & pend_writes_o) != '0);

  assign issue_ready_o = any_free && !conflict;
  assign issue_id_o    = free_id;
  assign accept        = issue_valid_i && issue_ready_o;

endmodule

// File: tb/tb_vproc_hazard_tracker.sv
// Scenario bench for the hazard tracker; issued ids checked via scoreboard.
// Inputs change 1ns after the rising edge, outputs sampled on the falling edge.
module tb_vproc_hazard_tracker;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             issue_valid;
  logic             issue_ready;
  logic [31:0]      issue_rd;
  logic [31:0]      issue_wr;
  logic [2:0]       issue_id;
  logic [1:0]       rd_clr_v;
  logic [1:0][2:0]  rd_clr_id;
  logic [1:0]       wr_clr_v;
  logic [1:0][2:0]  wr_clr_id;
  logic [31:0]      pend_reads;
  logic [31:0]      pend_writes;
  logic [3:0]       inflight;

  int tests_run = 0;
  int fails     = 0;
  logic [2:0] exp_q[$];

  always #5 clk = ~clk;

  vproc_hazard_tracker #(
    .VREG_CNT (32),
    .OP_CNT   (8),
    .PIPE_CNT (2)
  ) dut (
    .clk_i              (clk),
    .async_rst_ni       (rst_n),
    .issue_valid_i      (issue_valid),
    .issue_ready_o      (issue_ready),
    .issue_rd_hazards_i (issue_rd),
    .issue_wr_hazards_i (issue_wr),
    .issue_id_o         (issue_id),
    .rd_clear_valid_i   (rd_clr_v),
    .rd_clear_id_i      (rd_clr_id),
    .wr_clear_valid_i   (wr_clr_v),
    .wr_clear_id_i      (wr_clr_id),
    .pend_reads_o       (pend_reads),
    .pend_writes_o      (pend_writes),
    .inflight_o         (inflight)
  );

  // Scoreboard: every observed handshake consumes one expected slot id.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && issue_valid && issue_ready === 1'b1) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_issue: got id %0d, required no handshake", issue_id);
      end else begin
        logic [2:0] e;
        e = exp_q.pop_front();
        if (issue_id !== e) begin
          fails++;
          $display("FAIL issue_id: got %0d, required %0d", issue_id, e);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    issue_valid = 1'b0;
    issue_rd    = '0;
    issue_wr    = '0;
    rd_clr_v    = '0;
    wr_clr_v    = '0;
    rd_clr_id   = '0;
    wr_clr_id   = '0;
  endtask

  task automatic issue(input logic [31:0] rd, input logic [31:0] wr,
                       input logic [2:0] id);
    exp_q.push_back(id);
    issue_valid = 1'b1;
    issue_rd    = rd;
    issue_wr    = wr;
    @(negedge clk);
    tests_run++;
    if (issue_ready !== 1'b1) begin
      fails++;
      $display("FAIL issue_accept: ready %b, required 1 (id %0d)", issue_ready, id);
    end
    cyc();
    issue_valid = 1'b0;
    issue_rd    = '0;
    issue_wr    = '0;
  endtask

  task automatic clear_all();
    for (int j = 0; j < 4; j++) begin
      rd_clr_v     = 2'b11;
      wr_clr_v     = 2'b11;
      rd_clr_id[0] = 3'(2 * j);
      rd_clr_id[1] = 3'(2 * j + 1);
      wr_clr_id[0] = 3'(2 * j);
      wr_clr_id[1] = 3'(2 * j + 1);
      cyc();
    end
    rd_clr_v = '0;
    wr_clr_v = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #3;
    tests_run++;
    if (issue_ready !== 1'b1 || pend_reads !== 32'h0 || pend_writes !== 32'h0 ||
        inflight !== 4'd0 || issue_id !== 3'd0) begin
      fails++;
      $display("FAIL reset: rdy=%b pr=%h pw=%h inf=%0d id=%0d, required 1 0 0 0 0",
               issue_ready, pend_reads, pend_writes, inflight, issue_id);
    end
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    issue(32'h6, 32'h1, 3'd0);
    @(negedge clk);
    tests_run++;
    if (pend_reads !== 32'h6 || pend_writes !== 32'h1 || inflight !== 4'd1) begin
      fails++;
      $display("FAIL basic_pend: pr=%h pw=%h inf=%0d, required 6 1 1",
               pend_reads, pend_writes, inflight);
    end
    cyc();
    clear_all();
    @(negedge clk);
    tests_run++;
    if (inflight !== 4'd0) begin
      fails++;
      $display("FAIL basic_drain: inflight %0d, required 0", inflight);
    end
    cyc();
  endtask

  task automatic test_raw();
    issue(32'h0, 32'h1, 3'd0);
    exp_q.push_back(3'd0);
    issue_valid  = 1'b1;
    issue_rd     = 32'h1;
    wr_clr_v     = 2'b01;
    wr_clr_id[0] = 3'd0;
    @(negedge clk);
    tests_run++;
    if (issue_ready !== 1'b0) begin
      fails++;
      $display("FAIL raw_block: ready %b, required 0", issue_ready);
    end
    cyc();
    wr_clr_v = '0;
    @(negedge clk);
    tests_run++;
    if (issue_ready !== 1'b1) begin
      fails++;
      $display("FAIL raw_release: ready %b, required 1", issue_ready);
    end
    cyc();
    idle_inputs();
    clear_all();
    @(negedge clk);
    tests_run++;
    if (inflight !== 4'd0) begin
      fails++;
      $display("FAIL raw_drain: inflight %0d, required 0", inflight);
    end
    cyc();
  endtask

  task automatic test_war();
    // Producer still writing: the released WAR issue must take slot 1.
    issue(32'h4, 32'h2, 3'd0);
    exp_q.push_back(3'd1);
    issue_valid  = 1'b1;
    issue_wr     = 32'h4;
    rd_clr_v     = 2'b01;
    rd_clr_id[0] = 3'd0;
    @(negedge clk);
    tests_run++;
    if (issue_ready !== 1'b0) begin
      fails++;
      $display("FAIL war_block: ready %b, required 0", issue_ready);
    end
    cyc();
    rd_clr_v = '0;
    @(negedge clk);
    cyc();
    idle_inputs();
    @(negedge clk);
    tests_run++;
    if (pend_reads !== 32'h0 || pend_writes !== 32'h6 || inflight !== 4'd2) begin
      fails++;
      $display("FAIL war_busy: pr=%h pw=%h inf=%0d, required 0 6 2",
               pend_reads, pend_writes, inflight);
    end
    cyc();
    clear_all();
    // Read-only producer frees on its read clear, so slot 0 is reused.
    issue(32'h4, 32'h0, 3'd0);
    exp_q.push_back(3'd0);
    issue_valid  = 1'b1;
    issue_wr     = 32'h4;
    rd_clr_v     = 2'b10;
    rd_clr_id[1] = 3'd0;
    @(negedge clk);
    tests_run++;
    if (issue_ready !== 1'b0) begin
      fails++;
      $display("FAIL war2_block: ready %b, required 0", issue_ready);
    end
    cyc();
    rd_clr_v = '0;
    @(negedge clk);
    cyc();
    idle_inputs();
    @(negedge clk);
    tests_run++;
    if (pend_writes !== 32'h4 || inflight !== 4'd1) begin
      fails++;
      $display("FAIL war2_reuse: pw=%h inf=%0d, required 4 1", pend_writes, inflight);
    end
    cyc();
    clear_all();
  endtask

  task automatic test_full();
    issue_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      issue_rd = 32'h1 << (2 * i);
      issue_wr = 32'h1 << (2 * i + 1);
      exp_q.push_back(3'(i));
      @(negedge clk);
      cyc();
    end
    issue_rd     = '0;
    issue_wr     = '0;
    rd_clr_v     = 2'b01;
    rd_clr_id[0] = 3'd3;
    wr_clr_v     = 2'b10;
    wr_clr_id[1] = 3'd3;
    @(negedge clk);
    tests_run++;
    if (inflight !== 4'd8 || issue_ready !== 1'b0) begin
      fails++;
      $display("FAIL full: inf=%0d ready=%b, required 8 0", inflight, issue_ready);
    end
    tests_run++;
    if (pend_reads !== 32'h5555 || pend_writes !== 32'haaaa) begin
      fails++;
      $display("FAIL full_pend: pr=%h pw=%h, required 5555 aaaa", pend_reads, pend_writes);
    end
    cyc();
    rd_clr_v = '0;
    wr_clr_v = '0;
    issue_rd = 32'h40;
    issue_wr = 32'h80;
    exp_q.push_back(3'd3);
    @(negedge clk);
    tests_run++;
    if (inflight !== 4'd7) begin
      fails++;
      $display("FAIL full_free3: inflight %0d, required 7", inflight);
    end
    cyc();
    idle_inputs();
    @(negedge clk);
    tests_run++;
    if (inflight !== 4'd8 || pend_reads !== 32'h5555) begin
      fails++;
      $display("FAIL full_refill: inf=%0d pr=%h, required 8 5555", inflight, pend_reads);
    end
    cyc();
    clear_all();
  endtask

  task automatic test_back_to_back();
    issue(32'h1, 32'h2, 3'd0);
    issue(32'h4, 32'h8, 3'd1);
    issue(32'h10, 32'h20, 3'd2);
    exp_q.push_back(3'd3);
    issue_valid  = 1'b1;
    issue_rd     = 32'h100;
    issue_wr     = 32'h200;
    rd_clr_v     = 2'b01;
    rd_clr_id[0] = 3'd1;
    wr_clr_v     = 2'b10;
    wr_clr_id[1] = 3'd1;
    @(negedge clk);
    cyc();
    idle_inputs();
    @(negedge clk);
    tests_run++;
    if (inflight !== 4'd3 || pend_reads !== 32'h111 || pend_writes !== 32'h222) begin
      fails++;
      $display("FAIL swap: inf=%0d pr=%h pw=%h, required 3 111 222",
               inflight, pend_reads, pend_writes);
    end
    cyc();
    rd_clr_v     = 2'b11;
    rd_clr_id[0] = 3'd5;
    rd_clr_id[1] = 3'd5;
    wr_clr_v     = 2'b01;
    wr_clr_id[0] = 3'd5;
    cyc();
    idle_inputs();
    @(negedge clk);
    tests_run++;
    if (inflight !== 4'd3 || pend_reads !== 32'h111 || pend_writes !== 32'h222 ||
        issue_id !== 3'd1) begin
      fails++;
      $display("FAIL idle_clear: inf=%0d pr=%h pw=%h id=%0d, required 3 111 222 1",
               inflight, pend_reads, pend_writes, issue_id);
    end
    cyc();
    // Op with no hazards is busy for exactly one cycle.
    issue(32'h0, 32'h0, 3'd1);
    @(negedge clk);
    tests_run++;
    if (inflight !== 4'd4) begin
      fails++;
      $display("FAIL zero_op_busy: inflight %0d, required 4", inflight);
    end
    cyc();
    @(negedge clk);
    tests_run++;
    if (inflight !== 4'd3) begin
      fails++;
      $display("FAIL zero_op_free: inflight %0d, required 3", inflight);
    end
    cyc();
  endtask

  task automatic test_async_reset();
    issue(32'h400, 32'h800, 3'd1);
    @(negedge clk);
    tests_run++;
    if (inflight !== 4'd4) begin
      fails++;
      $display("FAIL pre_reset: inflight %0d, required 4", inflight);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (issue_ready !== 1'b1 || pend_reads !== 32'h0 || pend_writes !== 32'h0 ||
        inflight !== 4'd0 || issue_id !== 3'd0) begin
      fails++;
      $display("FAIL async_reset: rdy=%b pr=%h pw=%h inf=%0d id=%0d, required 1 0 0 0 0",
               issue_ready, pend_reads, pend_writes, inflight, issue_id);
    end
    cyc();
    cyc();
    rst_n        = 1'b1;
    rd_clr_v     = 2'b01;
    rd_clr_id[0] = 3'd2;
    wr_clr_v     = 2'b01;
    wr_clr_id[0] = 3'd2;
    cyc();
    idle_inputs();
    @(negedge clk);
    tests_run++;
    if (inflight !== 4'd0 || pend_reads !== 32'h0) begin
      fails++;
      $display("FAIL stale_clear: inf=%0d pr=%h, required 0 0", inflight, pend_reads);
    end
    cyc();
    issue(32'h3, 32'h4, 3'd0);
    clear_all();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_raw();
    test_war();
    test_full();
    test_back_to_back();
    test_async_reset();
    repeat (2) cyc();
    tests_run++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d ids never issued, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/vproc_hazard_tracker.md
VPROC_HAZARD_TRACKER -- requirements
Module: vproc_hazard_tracker

Interface
REQ-001 SHALL have parameter VREG_CNT, default 32, number of vector registers (mask width).
REQ-002 SHALL have parameter OP_CNT, default 8, number of in-flight operation slots (power of 2, >=2).
REQ-003 SHALL have parameter PIPE_CNT, default 2, number of independent completion ports.
REQ-004 SHALL have port clk_i  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port async_rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port issue_valid_i  input  1  an operation requests issue.
REQ-007 SHALL have port issue_ready_o  output  1  the operation is accepted this cycle.
REQ-008 SHALL have port issue_rd_hazards_i  input  VREG_CNT  vregs read by the operation.
REQ-009 SHALL have port issue_wr_hazards_i  input  VREG_CNT  vregs written by the operation.
REQ-010 SHALL have port issue_id_o  output  $clog2(OP_CNT)  slot allocated on handshake.
REQ-011 SHALL have port rd_clear_valid_i  input  PIPE_CNT  per port, source reads of a slot finished.
REQ-012 SHALL have port rd_clear_id_i  input  PIPE_CNT x $clog2(OP_CNT)  slot id per rd_clear port.
REQ-013 SHALL have port wr_clear_valid_i  input  PIPE_CNT  per port, writeback of a slot finished.
REQ-014 SHALL have port wr_clear_id_i  input  PIPE_CNT x $clog2(OP_CNT)  slot id per wr_clear port.
REQ-015 SHALL have port pend_reads_o  output  VREG_CNT  OR of read masks of all busy, read-pending slots.
REQ-016 SHALL have port pend_writes_o  output  VREG_CNT  OR of write masks of all busy, write-pending slots.
REQ-017 SHALL have port inflight_o  output  $clog2(OP_CNT)+1  count of busy slots.

Function
REQ-018 SHALL hold per slot: busy, rd_mask, wr_mask (rd_mask/wr_mask zeroed as respective clears arrive).
REQ-019 SHALL drive issue_ready_o = any slot free AND (rd_hazards & pend_writes_o)==0 AND (wr_hazards & pend_reads_o)==0 AND (wr_hazards & pend_writes_o)==0, using registered state only.
REQ-020 SHALL drive issue_id_o combinationally as lowest-index free slot; value meaningful only when a slot is free.
REQ-021 SHALL on issue_valid_i && issue_ready_o set that slot busy and load both masks, visible on pend_* next cycle.
REQ-022 SHALL zero rd_mask of slot k at the clock edge where any rd_clear port carries valid with id k; likewise wr_mask for wr_clear.
REQ-023 SHALL free a slot in the same edge its last nonzero mask becomes zero; a slot accepted with both masks zero frees the following cycle.
REQ-024 SHALL ignore clears addressing a non-busy slot; duplicate clears on several ports for one slot act as one.
REQ-025 SHALL apply clears only from the next cycle onward: a clear in cycle N does not unblock issue_ready_o in cycle N.
REQ-026 SHALL keep inflight_o equal to popcount of busy; issue and free in one cycle net out.
REQ-027 SHALL never allocate a busy slot; with OP_CNT busy, issue_ready_o SHALL be 0 regardless of masks.

Reset
REQ-028 SHALL asynchronously clear all busy bits and masks on async_rst_ni low; issue_ready_o=1 (if no inputs conflict), pend_reads_o=0, pend_writes_o=0, inflight_o=0, issue_id_o=0.
REQ-029 SHALL drop all in-flight slots on reset mid-operation; clears for pre-reset ids after reset SHALL be ignored.

Structure
REQ-030 SHALL place the hazard mask typedef (VREG_CNT-wide) and slot id width function in vproc_pkg.
REQ-031 SHALL implement one slot as sub-module vproc_hazard_slot (busy, masks, clear matching), instantiated OP_CNT times.

Verification
REQ-032 SHALL test: reset, issue rd=0x6 wr=0x1 -> id 0, next cycle pend_reads_o=0x6, pend_writes_o=0x1, inflight_o=1.
REQ-033 SHALL test: slot0 writes 0x1, issue rd=0x1 -> ready 0 (RAW); wr_clear id0 -> ready 1 one cycle later.
REQ-034 SHALL test: slot0 reads 0x4, issue wr=0x4 -> ready 0 (WAR); rd_clear id0 -> accepted, id 0 reused only if wr already cleared else id 1.
REQ-035 SHALL test: fill 8 disjoint ops -> inflight_o=8, ready 0; rd+wr clear slot 3 on ports 0/1 simultaneously -> next issue gets id 3.
REQ-036 SHALL test: same-cycle issue and clear of another slot -> inflight_o unchanged; clear to idle slot 5 -> no state change.
REQ-037 SHALL test: async_rst_ni low with 4 busy slots -> all outputs at reset values without a clock edge.
